// File: rtl/display_pkg.sv
// Shared types and segment decoding for the multiplexed hex display.
// Segment codes are active-low {a,b,c,d,e,f,g,dp}.
package display_pkg;

    typedef logic [7:0] seg_t;

    localparam seg_t SEG_OFF = 8'hFF;

    function automatic seg_t hex_to_seg(input logic [3:0] nibble);
        seg_t s;
        s = SEG_OFF;
        unique case (nibble)
            4'h0: s = 8'h03;
            4'h1: s = 8'h9F;
            4'h2: s = 8'h25;
            4'h3: s = 8'h0D;
            4'h4: s = 8'h99;
            4'h5: s = 8'h49;
            4'h6: s = 8'h41;
            4'h7: s = 8'h1F;
            4'h8: s = 8'h01;
            4'h9: s = 8'h19;
            4'hA: s = 8'h11;
            4'hB: s = 8'hC1;
            4'hC: s = 8'h63;
            4'hD: s = 8'h85;
            4'hE: s = 8'h61;
            4'hF: s = 8'h71;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/display_hex_scan_if.sv
// Bundle between UI/datapath logic and the scanned display driver.
// master = the logic supplying the value, slave = the driver.
interface display_hex_scan_if #(
    parameter int N_DIGITS = 8,
    parameter int BRIGHT_W = 4
);
    logic [4*N_DIGITS-1:0] numero_entrada;
    logic                  power_on;
    logic [N_DIGITS-1:0]   dp_mask;
    logic [N_DIGITS-1:0]   blink_mask;
    logic                  lz_blank;
    logic [BRIGHT_W-1:0]   brillo;
    logic                  frame_start;
    logic [7:0]            SEG;
    logic [N_DIGITS-1:0]   ANODO;

    modport master (
        output numero_entrada, power_on, dp_mask, blink_mask,
        output lz_blank, brillo,
        input  frame_start, SEG, ANODO
    );

    modport slave (
        input  numero_entrada, power_on, dp_mask, blink_mask,
        input  lz_blank, brillo,
        output frame_start, SEG, ANODO
    );
endinterface

// File: rtl/display_hex_scan_timer.sv
// Refresh prescaler, digit index and blink frame counter.
// tick_next / blink_flip let the caller register outputs for the next cycle.
module scan_timer #(
    parameter int REFRESH_DIV  = 100000,
    parameter int N_DIGITS     = 8,
    parameter int BLINK_FRAMES = 64,
    parameter int IDX_W        = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1
) (
    input  logic             clk,
    input  logic             reset,
    output logic             tick,
    output logic             tick_next,
    output logic [IDX_W-1:0] digit_idx,
    output logic             frame_start,
    output logic             blink_phase,
    output logic             blink_flip
);
    localparam int CNT_W = $clog2(REFRESH_DIV);
    localparam int FR_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [CNT_W-1:0] cnt;
    logic [FR_W-1:0]  frames;
    logic             last_idx;
    logic             last_frame;

    assign tick        = cnt == CNT_W'(REFRESH_DIV - 1);
    assign tick_next   = cnt == CNT_W'(REFRESH_DIV - 2);
    assign last_idx    = digit_idx == IDX_W'(N_DIGITS - 1);
    assign last_frame  = frames == FR_W'(BLINK_FRAMES - 1);
    assign frame_start = tick & last_idx;
    assign blink_flip  = frame_start & last_frame;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt         <= '0;
            digit_idx   <= '0;
            frames      <= '0;
            blink_phase <= 1'b0;
        end else begin
            cnt <= tick ? '0 : cnt + 1'b1;
            if (tick)
                digit_idx <= last_idx ? '0 : digit_idx + 1'b1;
            if (frame_start)
                frames <= last_frame ? '0 : frames + 1'b1;
            if (blink_flip)
                blink_phase <= ~blink_phase;
        end
    end
endmodule

// File: rtl/display_hex_scan.sv
// Multiplexed 7-segment driver with frame snapshot, LZ blanking, blink and PWM.
// Output registers are loaded from next-cycle state so they track the scan exactly.
module display_hex_scan
    import display_pkg::*;
#(
    parameter int N_DIGITS     = 8,
    parameter int REFRESH_DIV  = 100000,
    parameter int BRIGHT_W     = 4,
    parameter int BLINK_FRAMES = 64
) (
    input logic              clk,
    input logic              reset,
    display_hex_scan_if.slave bus
);
    localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

    logic                  tick, tick_next, wrap, blink_phase, blink_flip;
    logic [IDX_W-1:0]      idx, idx_next;
    logic [4*N_DIGITS-1:0] snap_val, val_n;
    logic [N_DIGITS-1:0]   snap_dp, dp_n, snap_blink, blink_n, upper_zero;
    logic                  snap_lz, lz_n, phase_n;
    logic [BRIGHT_W-1:0]   pwm_cnt, pwm_next;
    logic [3:0]            nib;
    logic                  pwm_on, lz_hide, blink_hide, lit;

    scan_timer #(
        .REFRESH_DIV (REFRESH_DIV),
        .N_DIGITS    (N_DIGITS),
        .BLINK_FRAMES(BLINK_FRAMES),
        .IDX_W       (IDX_W)
    ) u_timer (
        .clk        (clk),
        .reset      (reset),
        .tick       (tick),
        .tick_next  (tick_next),
        .digit_idx  (idx),
        .frame_start(wrap),
        .blink_phase(blink_phase),
        .blink_flip (blink_flip)
    );

    assign idx_next = !tick ? idx : (wrap ? '0 : idx + 1'b1);
    assign val_n    = wrap ? bus.numero_entrada : snap_val;
    assign dp_n     = wrap ? bus.dp_mask : snap_dp;
    assign blink_n  = wrap ? bus.blink_mask : snap_blink;
    assign lz_n     = wrap ? bus.lz_blank : snap_lz;
    assign phase_n  = blink_phase ^ blink_flip;
    assign pwm_next = tick ? '0 : pwm_cnt + 1'b1;

    // upper_zero[k]: every nibble at index >= k is zero
    always_comb begin
        logic acc;
        acc        = 1'b1;
        upper_zero = '0;
        for (int k = N_DIGITS - 1; k >= 0; k--) begin
            acc           = acc & (val_n[4*k +: 4] == 4'h0);
            upper_zero[k] = acc;
        end
    end

    assign nib        = val_n[{idx_next, 2'b00} +: 4];
    assign pwm_on     = (&bus.brillo) | (pwm_next < bus.brillo);
    assign lz_hide    = lz_n & (idx_next != '0) & upper_zero[idx_next];
    assign blink_hide = blink_n[idx_next] & phase_n;
    assign lit        = bus.power_on & pwm_on & ~tick_next
                      & ~lz_hide & ~blink_hide;

    always_ff @(posedge clk) begin
        if (reset) begin
            snap_val        <= '0;
            snap_dp         <= '0;
            snap_blink      <= '0;
            snap_lz         <= 1'b0;
            pwm_cnt         <= '0;
            bus.SEG         <= SEG_OFF;
            bus.ANODO       <= '1;
            bus.frame_start <= 1'b0;
        end else begin
            snap_val        <= val_n;
            snap_dp         <= dp_n;
            snap_blink      <= blink_n;
            snap_lz         <= lz_n;
            pwm_cnt         <= pwm_next;
            bus.frame_start <= wrap;
            if (lit) begin
                bus.SEG   <= hex_to_seg(nib) & ~{7'b0, dp_n[idx_next]};
                bus.ANODO <= ~(N_DIGITS'(1) << idx_next);
            end else begin
                bus.SEG   <= SEG_OFF;
                bus.ANODO <= '1;
            end
        end
    end
endmodule

// File: tb/tb_display_hex_scan.sv
// Directed bench for display_hex_scan with a per-cycle scoreboard model.
// Expected outputs come from an arithmetic scan model keyed by cycles since reset.
module tb_display_hex_scan;
    localparam int N   = 4;
    localparam int DIV = 4;
    localparam int BW  = 2;
    localparam int BF  = 2;
    localparam int FR  = N * DIV;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    display_hex_scan_if #(.N_DIGITS(N), .BRIGHT_W(BW)) dif ();

    display_hex_scan #(
        .N_DIGITS(N), .REFRESH_DIV(DIV),
        .BRIGHT_W(BW), .BLINK_FRAMES(BF)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (dif)
    );

    int total = 0;
    int bad   = 0;
    int n     = 0;
    logic [15:0] sv;
    logic [3:0]  sdp, sbl;
    logic        slz;
    logic [12:0] sb[$];

    function automatic logic [7:0] code(input logic [3:0] h);
        case (h)
            4'h0: return 8'h03;  4'h1: return 8'h9F;
            4'h2: return 8'h25;  4'h3: return 8'h0D;
            4'h4: return 8'h99;  4'h5: return 8'h49;
            4'h6: return 8'h41;  4'h7: return 8'h1F;
            4'h8: return 8'h01;  4'h9: return 8'h19;
            4'hA: return 8'h11;  4'hB: return 8'hC1;
            4'hC: return 8'h63;  4'hD: return 8'h85;
            4'hE: return 8'h61;  default: return 8'h71;
        endcase
    endfunction

    // {frame_start, ANODO, SEG} for cycle n after reset release
    function automatic logic [12:0] predict(input logic pwr, input logic [1:0] br);
        int c, k, f;
        logic fs, dark;
        logic [3:0] an;
        logic [7:0] sg;
        c  = n % DIV;
        k  = (n / DIV) % N;
        f  = n / FR;
        fs = (c == 0) && (k == 0) && (n > 0);
        dark = (c == DIV - 1) || !pwr
            || (slz && k > 0 && (sv >> (4 * k)) == 16'h0)
            || (sbl[k] && ((f / BF) % 2 == 1))
            || !(br == 2'd3 || (c % (1 << BW)) < int'(br));
        if (dark) return {fs, 4'hF, 8'hFF};
        an = 4'hF;
        an[k] = 1'b0;
        sg = code(sv[4*k +: 4]);
        if (sdp[k]) sg[0] = 1'b0;
        return {fs, an, sg};
    endfunction

    task automatic cyc();
        logic [12:0] e, got;
        @(posedge clk);
        if (reset) begin
            n = 0; sv = '0; sdp = '0; sbl = '0; slz = 1'b0;
            e = {1'b0, 4'hF, 8'hFF};
        end else begin
            if (n % FR == FR - 1) begin
                sv  = dif.numero_entrada;
                sdp = dif.dp_mask;
                sbl = dif.blink_mask;
                slz = dif.lz_blank;
            end
            n++;
            e = predict(dif.power_on, dif.brillo);
        end
        sb.push_back(e);
        @(negedge clk);
        got = {dif.frame_start, dif.ANODO, dif.SEG};
        e = sb.pop_front();
        total++;
        assert (got === e) else begin
            bad++;
            $error("FAIL scan n=%0d got=%h exp=%h", n, got, e);
        end
    endtask

    task automatic run(input int cycles);
        for (int i = 0; i < cycles; i++) cyc();
    endtask

    task automatic run_to(input int pos);
        int lim;
        lim = 0;
        do begin
            cyc();
            lim++;
        end while ((n % FR) != pos && lim < 3 * FR);
        if ((n % FR) != pos) begin
            total++;
            bad++;
            $error("FAIL run_to got=%0d exp=%0d", n % FR, pos);
        end
    endtask

    task automatic chk(input string tag, input logic fs,
                       input logic [3:0] an, input logic [7:0] sg);
        logic [12:0] got, exp;
        got = {dif.frame_start, dif.ANODO, dif.SEG};
        exp = {fs, an, sg};
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    initial begin
        dif.numero_entrada = 16'h12AF;
        dif.power_on       = 1'b1;
        dif.dp_mask        = 4'b0;
        dif.blink_mask     = 4'b0;
        dif.lz_blank       = 1'b0;
        dif.brillo         = 2'd3;

        run(3);
        chk("reset", 1'b0, 4'hF, 8'hFF);
        reset = 1'b0;
        run(2 * FR);
        run_to(0);  chk("t1_d0", 1'b1, 4'hE, 8'h71);
        run_to(3);  chk("t1_tick", 1'b0, 4'hF, 8'hFF);
        run_to(4);  chk("t1_d1", 1'b0, 4'hD, 8'h11);
        run_to(8);  chk("t1_d2", 1'b0, 4'hB, 8'h25);
        run_to(12); chk("t1_d3", 1'b0, 4'h7, 8'h9F);

        dif.numero_entrada = 16'h1111;
        run_to(0);
        run_to(8);  chk("t2_old2", 1'b0, 4'hB, 8'h9F);
        dif.numero_entrada = 16'h2222;
        run_to(12); chk("t2_old3", 1'b0, 4'h7, 8'h9F);
        run_to(0);  chk("t2_new0", 1'b1, 4'hE, 8'h25);
        run_to(8);  chk("t2_new2", 1'b0, 4'hB, 8'h25);

        dif.lz_blank       = 1'b1;
        dif.numero_entrada = 16'h0050;
        run_to(0);  chk("t3_d0", 1'b1, 4'hE, 8'h03);
        run_to(4);  chk("t3_d1", 1'b0, 4'hD, 8'h49);
        run_to(8);  chk("t3_d2", 1'b0, 4'hF, 8'hFF);
        run_to(12); chk("t3_d3", 1'b0, 4'hF, 8'hFF);
        dif.numero_entrada = 16'h0000;
        run_to(0);  chk("t3_z0", 1'b1, 4'hE, 8'h03);
        run_to(4);  chk("t3_z1", 1'b0, 4'hF, 8'hFF);

        dif.lz_blank       = 1'b0;
        dif.blink_mask     = 4'b0001;
        dif.dp_mask        = 4'b0010;
        dif.numero_entrada = 16'h0008;
        run(6 * FR);

        dif.blink_mask = 4'b0;
        dif.dp_mask    = 4'b0;
        dif.brillo     = 2'd1;
        run(2 * FR);
        dif.brillo = 2'd0;
        run(FR);
        dif.brillo   = 2'd3;
        dif.power_on = 1'b0;
        run(FR);
        dif.power_on = 1'b1;

        dif.numero_entrada = 16'h12AF;
        run(2 * FR);
        run_to(8);  chk("t6_pre", 1'b0, 4'hB, 8'h25);
        reset = 1'b1;
        cyc();      chk("t6_rst", 1'b0, 4'hF, 8'hFF);
        reset = 1'b0;
        cyc();
        cyc();      chk("t6_first", 1'b0, 4'hE, 8'h03);
        run(2 * FR);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/display_hex_scan.md
Name: display_hex_scan

Overview:
- Parametrised multiplexed 7-segment driver, the successor to the fixed 8-digit hex display driver.
- Runs on the system clock with an internal refresh prescaler. Supports any digit count, per-digit decimal points, leading-zero blanking, per-digit blink and PWM brightness.
- Snapshots the value once per scan frame so a changing input never tears.
- Sits between datapath/UI logic and the board SEG/ANODO pins.

Parameters:
- N_DIGITS, 8, number of digits scanned (1..16; need not be a power of two).
- REFRESH_DIV, 100000, clk cycles per digit slot (>=2).
- BRIGHT_W, 4, brightness/PWM counter width.
- BLINK_FRAMES, 64, full scan frames per blink half-period (>=1).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- numero_entrada  in  4*N_DIGITS  hex value; nibble k drives digit k (digit 0 = rightmost)
- power_on  in  1  0 = all anodes off
- dp_mask  in  N_DIGITS  1 = light decimal point of digit k
- blink_mask  in  N_DIGITS  1 = digit k blinks
- lz_blank  in  1  1 = suppress leading zeros
- brillo  in  BRIGHT_W  brightness: 0 = dark, all-ones = full on
- frame_start  out  1  one-cycle pulse when digit 0 slot begins
- SEG  out  8  {a,b,c,d,e,f,g,dp}, active-low
- ANODO  out  N_DIGITS  one-hot-low digit enable

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high.
- Reset values:
  - SEG = 8'hFF, ANODO = all ones, frame_start = 0.
  - Prescaler, digit index, PWM counter and blink counter = 0; blink phase = 0 (visible).
  - Snapshot registers = 0.
- Prescaler: counts 0..REFRESH_DIV-1 and wraps. tick = (count == REFRESH_DIV-1).
- Digit index: increments on tick. Wraps N_DIGITS-1 -> 0 explicitly, with no power-of-two aliasing.
- Snapshot: on a tick that wraps the index to 0, latch numero_entrada, dp_mask, blink_mask and lz_blank. The same cycle also pulses frame_start. All decode uses the snapshots only. brillo and power_on act immediately.
- Blink counter: counts frames 0..BLINK_FRAMES-1; blink phase toggles on wrap.
- Leading-zero blanking: with snapshot lz_blank = 1, digit k is blank if every nibble at index >= k is zero. Digit 0 is never blanked by this rule, so the value 0 shows a single "0".
- A digit is dark (ANODO bit 1, SEG 8'hFF) when any of these holds:
  - power_on = 0;
  - it is LZ-blanked;
  - blink_mask[k] = 1 and blink phase = 1;
  - the PWM gate is off.
- A dp bit alone does not light a LZ-blanked digit.
- PWM: a free-running BRIGHT_W-bit counter, reset to 0 on every tick. Gate on when pwm_cnt < brillo, or when brillo is all ones.
- Segment codes, active-low, dp bit = 1:
  - 0=03, 1=9F, 2=25, 3=0D, 4=99, 5=49, 6=41, 7=1F
  - 8=01, 9=19, A=11, b=C1, C=63, d=85, E=61, F=71
  - dp_mask[k] clears bit 0.
- Outputs are registered. ANODO/SEG reflect a new digit index 1 cycle after the tick; frame_start is aligned with that update.
- Break-before-make: in the cycle of a tick, ANODO is forced all ones, so one dark cycle separates digit slots (no ghosting).
- Reset mid-frame: all outputs return to reset values on the next edge. Scanning restarts at digit 0 with new snapshots taken at the first wrap.

Decomposition:
- Package display_pkg holds:
  - typedef seg_t (logic [7:0]);
  - constant SEG_OFF = 8'hFF;
  - function hex_to_seg(nibble) returning seg_t.
- Sub-module scan_timer (prescaler + digit index + frame/blink counters, parameters REFRESH_DIV, N_DIGITS, BLINK_FRAMES), outputs tick, digit_idx, frame_start, blink_phase.

Test Plan (N_DIGITS=4, REFRESH_DIV=4, BRIGHT_W=2, BLINK_FRAMES=2):
1. Reset held 3 cycles, then released with numero_entrada=16'h12AF, brillo=3, power_on=1:
   - outputs stay FF/F during reset;
   - after the first frame, ANODO cycles E,D,B,7 every 4 cycles;
   - SEG = 71,11,25,9F respectively;
   - ANODO is all ones in each tick cycle.
2. Change numero_entrada mid-frame from 16'h1111 to 16'h2222 while digit 2 is displayed:
   - digits 2 and 3 still show 9F;
   - 25 appears only after the next frame_start.
3. lz_blank=1, value 16'h0050:
   - digits 3 and 2 dark; digit 1 = 49, digit 0 = 03.
   - value 0: only digit 0 lit, showing 03.
4. blink_mask=4'b0001, dp_mask=4'b0010, value 16'h0008:
   - digit 0 = 01 for 2 frames, dark for 2 frames, repeating;
   - digit 1 = 02 (0 with dp) throughout.
5. brillo=1 (W=2): the active anode is low for 1 of 4 cycles per slot. brillo=0: never lit. power_on=0: ANODO = F continuously.
6. Reset asserted while digit 2 is active: next edge gives SEG=FF, ANODO=F, frame_start=0. After release, the first lit digit is digit 0.
